// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and constants for the UART TX bridge
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;
  localparam int DEFAULT_CLK_DIV = 868;
  localparam int BAUD_CNT_W = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push on a full FIFO is accepted only when a pop happens on the same edge
// Ports: clk, rst (async, active-high), push/din write side, pop/dout read side
//        (dout shows the head combinationally), full, empty, level (occupancy).
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] lvl_q, lvl_d;
  logic wr, rd;
  always_comb begin
    rd = pop & ~empty;
    wr = push & (~full | rd);
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(rd);
    lvl_d = lvl_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= din;
  assign dout = mem_q[rp_q];
  assign full = lvl_q == (AW+1)'(DEPTH);
  assign empty = lvl_q == '0;
  assign level = lvl_q;
endmodule

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: buffers core UART byte strobes in a FIFO and serialises them as 8N1 on txd
// Ports: clk, rst (async, active-high), char_in/char_valid push strobe (no backpressure),
//        overflow_clr clears the sticky overflow flag, txd serial out (idle high),
//        busy (frame in progress or FIFO non-empty), overflow, fifo_level.
// Build option: UART_TX_PARITY_EN adds an even-parity bit between data and stop (8E1).
module uart_tx_bridge
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         char_in,
  input  logic               char_valid,
  input  logic               overflow_clr,
  output logic               txd,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);
  localparam logic [BAUD_CNT_W-1:0] LOAD = BAUD_CNT_W'(CLK_DIV - 1);
  state_e state_q, state_d;
  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, fifo_dout;
  logic txd_q, txd_d, ov_q, ov_d, pop, full, empty, tick;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (char_valid),
    .pop   (pop),
    .din   (char_in),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  assign tick = cnt_q == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      txd_q <= 1'b1;
      ov_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
      ov_q <= ov_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  // The counter rests at 0 in IDLE, so IDLE sees a tick on every edge and pops as soon as data arrives.
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? cnt_q : cnt_q - BAUD_CNT_W'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    if (tick)
      case (state_q)
        IDLE, STOP: begin
          state_d = empty ? IDLE : START;
          pop = ~empty;
          shift_d = empty ? shift_q : fifo_dout;
          cnt_d = empty ? cnt_q : LOAD;
        end
        START: begin
          state_d = DATA;
          bit_d = '0;
          cnt_d = LOAD;
        end
        DATA: begin
          cnt_d = LOAD;
          shift_d = shift_q >> 1;
          bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          state_d = bit_q == 3'd7 ? PARITY : DATA;
`else
          state_d = bit_q == 3'd7 ? STOP : DATA;
`endif
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d = STOP;
          cnt_d = LOAD;
        end
`endif
        default: state_d = IDLE;
      endcase
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^fifo_dout : par_q;
`endif
  end
  // txd is registered from the next state so the line changes on the same edge as the state.
  always_comb begin
    txd_d = state_d == START ? 1'b0 :
            state_d == DATA  ? shift_d[0] :
`ifdef UART_TX_PARITY_EN
            state_d == PARITY ? par_d :
`endif
            1'b1;
    ov_d = (char_valid & full & ~pop) | (ov_q & ~overflow_clr);
  end
  assign txd = txd_q;
  assign overflow = ov_q;
  assign busy = (state_q != IDLE) | (fifo_level != '0);
endmodule

// File: tb/tb_uart_tx_bridge.sv
// tb_uart_tx_bridge: randomized scoreboard bench for uart_tx_bridge (CLK_DIV=4, FIFO_DEPTH=4)
module tb_uart_tx_bridge;
  localparam int D = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = NB * D;
  logic clk = 1'b0, rst = 1'b0, char_valid = 1'b0, overflow_clr = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic txd, busy, overflow;
  logic [2:0] fifo_level;
  uart_tx_bridge #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .char_in      (char_in),
    .char_valid   (char_valid),
    .overflow_clr (overflow_clr),
    .txd          (txd),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, edge_n = 0, t_free = 0;
  int push_e[$], start_e[$];
  logic [7:0] byte_q[$], sb[$];
  bit ov_exp = 0, ov_set = 0, ov_clr = 0, chk_en = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask
  always @(posedge clk) begin
    edge_n++;
    if (!rst) ov_exp = ov_set ? 1'b1 : ov_clr ? 1'b0 : ov_exp;
    ov_set = 0;
    ov_clr = 0;
  end
  // Reference: frames run back to back; a byte starts one edge after its push or when the line frees up.
  function automatic void expect_at(input int c, output logic etx, output int lvl, output bit act);
    etx = 1'b1;
    lvl = 0;
    act = 0;
    for (int i = 0; i < start_e.size(); i++) begin
      if (push_e[i] <= c && start_e[i] > c) lvl++;
      if (start_e[i] <= c && c < start_e[i] + FL) begin
        int p;
        act = 1;
        p = (c - start_e[i]) / D;
        etx = p == 0 ? 1'b0 : p <= 8 ? byte_q[i][p-1] : (PAR && p == 9) ? ^byte_q[i] : 1'b1;
      end
    end
  endfunction
  task automatic model_push(int c, logic [7:0] b);
    int cnt = 0;
    bit popc = 0;
    for (int i = 0; i < start_e.size(); i++) begin
      if (push_e[i] < c && start_e[i] >= c) cnt++;
      if (start_e[i] == c) popc = 1;
    end
    if (cnt == DEPTH && !popc) ov_set = 1;
    else begin
      int s;
      s = (c + 1 > t_free) ? c + 1 : t_free;
      push_e.push_back(c);
      start_e.push_back(s);
      byte_q.push_back(b);
      sb.push_back(b);
      t_free = s + FL;
    end
  endtask
  always @(negedge clk)
    if (!rst && chk_en) begin
      logic etx;
      int lvl;
      bit act;
      expect_at(edge_n, etx, lvl, act);
      check("txd", txd, etx);
      check("level", fifo_level, lvl);
      check("busy", busy, act || lvl != 0);
      check("overflow", overflow, ov_exp);
    end
  int dk = 0;
  bit dact = 0;
  logic [7:0] dbyte = 8'h00;
  always @(negedge clk)
    if (rst) dact = 0;
    else if (!dact) begin
      if (txd === 1'b0) begin
        dact = 1;
        dk = 0;
      end
    end else begin
      dk++;
      if (dk % D == D / 2) begin
        int p;
        p = dk / D;
        if (p == 0) check("start_bit", txd, 0);
        else if (p <= 8) dbyte[p-1] = txd;
        else if (PAR && p == 9) check("parity_bit", txd, ^dbyte);
        if (p == NB - 1) begin
          check("stop_bit", txd, 1);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame: got byte %0h expected none", dbyte);
          end else check("frame_byte", dbyte, sb.pop_front());
          dact = 0;
        end
      end
    end
  task automatic step(bit v, logic [7:0] b, bit clr);
    @(negedge clk);
    char_valid = v;
    char_in = b;
    overflow_clr = clr;
    if (clr) ov_clr = 1;
    if (v) model_push(edge_n + 1, b);
  endtask
  task automatic drain();
    int n = 0;
    while ((busy !== 1'b0 || edge_n < t_free) && n < 3000) begin
      step(0, 8'h00, 0);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got busy=%0b expected 0", busy);
    end
    repeat (3) step(0, 8'h00, 0);
    check("sb_empty", sb.size(), 0);
  endtask
  task automatic reset_mid();
    @(negedge clk);
    char_valid = 0;
    overflow_clr = 0;
    #1 rst = 1;
    dact = 0;
    #1;
    check("rst_txd", txd, 1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    push_e.delete();
    start_e.delete();
    byte_q.delete();
    sb.delete();
    t_free = 0;
    ov_exp = 0;
    ov_set = 0;
    ov_clr = 0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("init_txd", txd, 1);
    check("init_busy", busy, 0);
    check("init_overflow", overflow, 0);
    check("init_level", fifo_level, 0);
    rst = 0;
    chk_en = 1;
    step(1, 8'h55, 0);
    drain();
    step(1, 8'h41, 0);
    step(1, 8'h42, 0);
    drain();
    for (int i = 0; i < 6; i++) step(1, 8'h10 + 8'(i), 0);
    step(0, 8'h00, 0);
    check("ovf_set", overflow, 1);
    step(1, 8'h77, 1);
    step(0, 8'h00, 0);
    check("ovf_set_wins", overflow, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    check("ovf_cleared", overflow, 0);
    drain();
    for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0);
    begin
      int t;
      t = start_e[start_e.size() - 4];
      while (edge_n + 1 < t) step(0, 8'h00, 0);
      step(1, 8'h9E, 0);
      step(0, 8'h00, 0);
      check("fullpop_level", fifo_level, 4);
      check("fullpop_overflow", overflow, 0);
    end
    drain();
    step(1, 8'h3C, 0);
    begin
      int s;
      s = start_e[start_e.size() - 1];
      while (edge_n < s + 4 * D) step(0, 8'h00, 0);
    end
    reset_mid();
    step(1, 8'hA5, 0);
    drain();
    step(1, 8'h07, 0);
    drain();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 30) == 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
